clock_divider_prog: RTL and testbench

Parametrised, runtime-programmable successor to the fixed divide-by-2 pixel-clock divider. Derives a divided square wave (clk_out) and a one-cycle period strobe (tick) from the 50 MHz system clock. Divide ratio is loaded through a valid/ready handshake and applied glitch-free at the next period boundary. Drives pixel/peripheral timing logic at selectable rates (e.g. 25 MHz, 12.5 MHz, UART/baud-style ticks).

---
 rtl/clock_divider_prog_if.sv | 21 ++
 rtl/clock_divider_prog.sv | 95 +++++++++
 tb/tb_clock_divider_prog.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_prog_if.sv
// Ratio-load handshake bundle for clock_divider_prog.
// The master offers div_in/div_valid; the divider answers with div_ready.
interface clock_divider_prog_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;

  modport master (
    output div_in,
    output div_valid,
    input  div_ready
  );

  modport slave (
    input  div_in,
    input  div_valid,
    output div_ready
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: square wave, period tick, glitch-free reload.
// Optional macro CLKDIV_PHASE_RESTART_EN adds a phase restart input.
module clock_divider_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_PHASE_RESTART_EN
  input  logic             restart,
`endif
  clock_divider_prog_if.slave hs,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             take;
  logic             wrap;
  logic             apply;
  logic             rs;
  logic [CNT_W-1:0] div_clamp;

`ifdef CLKDIV_PHASE_RESTART_EN
  assign rs = restart;
`else
  assign rs = 1'b0;
`endif

  // Next-state: handshake capture, apply at period boundary, phase count.
  always_comb begin
    take      = hs.div_valid && !pend_v_q;
    wrap      = en && (cnt_q == div_q - 1'b1);
    apply     = pend_v_q && (rs || wrap);
    div_clamp = (hs.div_in < DIV_MIN) ? DIV_MIN : hs.div_in;
    div_d     = apply ? pend_q : div_q;
    pend_d    = take ? div_clamp : pend_q;
    pend_v_d  = pend_v_q;
    if (take) begin
      pend_v_d = 1'b1;
    end else if (apply) begin
      pend_v_d = 1'b0;
    end
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (rs) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = en;
    end else if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      clk_d  = (cnt_d >= (div_d >> 1));
      tick_d = wrap;
    end
  end

  // State register with synchronous reset to the default ratio.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= DIV_RST;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign hs.div_ready = !pend_v_q;
  assign clk_out      = clk_q;
  assign tick         = tick_q;
  assign cnt          = cnt_q;
  assign pending      = pend_v_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog.
// Expected waveforms are hand-derived per scenario.
module tb_clock_divider_prog;
  localparam int W = 16;

  logic         clk_50m = 1'b0;
  logic         rst;
  logic         en;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] cnt;
  logic         pending;
`ifdef CLKDIV_PHASE_RESTART_EN
  logic         restart;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  clock_divider_prog_if #(.CNT_W(W)) hs ();

  clock_divider_prog #(
    .CNT_W(W),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_50m(clk_50m),
    .rst(rst),
    .en(en),
`ifdef CLKDIV_PHASE_RESTART_EN
    .restart(restart),
`endif
    .hs(hs.slave),
    .clk_out(clk_out),
    .tick(tick),
    .cnt(cnt),
    .pending(pending)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic step_chk(input string tag, input int c,
                          input int ck, input int t);
    step();
    chk({tag, ".cnt"}, int'(cnt), c);
    chk({tag, ".clk"}, int'(clk_out), ck);
    chk({tag, ".tick"}, int'(tick), t);
  endtask

  task automatic hs_chk(input string tag, input int p);
    chk({tag, ".pend"}, int'(pending), p);
    chk({tag, ".rdy"}, int'(hs.div_ready), 1 - p);
  endtask

  task automatic offer(input int d);
    hs.div_in    = W'(d);
    hs.div_valid = 1'b1;
  endtask

  task automatic drop();
    hs.div_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    hs.div_in    = '0;
    hs.div_valid = 1'b0;
`ifdef CLKDIV_PHASE_RESTART_EN
    restart      = 1'b0;
`endif
    repeat (3) step();
    chk("rst.cnt", int'(cnt), 0);
    chk("rst.clk", int'(clk_out), 0);
    chk("rst.tick", int'(tick), 0);
    hs_chk("rst", 0);
    rst = 1'b0;
    en  = 1'b1;

    // N=2 legacy toggle
    step_chk("n2a", 1, 1, 0);
    step_chk("n2b", 0, 0, 1);
    step_chk("n2c", 1, 1, 0);
    step_chk("n2d", 0, 0, 1);

    // load 5 at cnt=0; current N=2 period completes
    offer(5);
    step_chk("l5a", 1, 1, 0);
    hs_chk("l5a", 1);
    drop();
    step_chk("l5b", 0, 0, 1);
    hs_chk("l5b", 0);
    step_chk("n5a", 1, 0, 0);
    step_chk("n5b", 2, 1, 0);
    step_chk("n5c", 3, 1, 0);
    step_chk("n5d", 4, 1, 0);
    step_chk("n5e", 0, 0, 1);

    // load 0 -> clamped to 2
    offer(0);
    step_chk("l0a", 1, 0, 0);
    hs_chk("l0a", 1);
    drop();
    step_chk("l0b", 2, 1, 0);
    step_chk("l0c", 3, 1, 0);
    step_chk("l0d", 4, 1, 0);
    step_chk("l0e", 0, 0, 1);
    hs_chk("l0e", 0);
    step_chk("c0a", 1, 1, 0);
    step_chk("c0b", 0, 0, 1);

    // load 1 -> clamped to 2
    offer(1);
    step_chk("l1a", 1, 1, 0);
    hs_chk("l1a", 1);
    drop();
    step_chk("l1b", 0, 0, 1);
    hs_chk("l1b", 0);
    step_chk("c1a", 1, 1, 0);
    step_chk("c1b", 0, 0, 1);

    // pending 7, second offer of 9 while busy is ignored
    offer(7);
    step_chk("l7a", 1, 1, 0);
    hs_chk("l7a", 1);
    offer(9);
    step_chk("l7b", 0, 0, 1);
    hs_chk("l7b", 0);
    drop();
    step_chk("n7a", 1, 0, 0);
    step_chk("n7b", 2, 0, 0);
    step_chk("n7c", 3, 1, 0);
    step_chk("n7d", 4, 1, 0);
    step_chk("n7e", 5, 1, 0);
    step_chk("n7f", 6, 1, 0);
    step_chk("n7g", 0, 0, 1);

    // transfer on the wrap edge: captured only, applied one period later
    repeat (6) step();
    chk("w7.cnt", int'(cnt), 6);
    offer(3);
    step_chk("wt", 0, 0, 1);
    hs_chk("wt", 1);
    drop();
    step_chk("wt1", 1, 0, 0);
    step_chk("wt2", 2, 0, 0);
    step_chk("wt3", 3, 1, 0);
    step_chk("wt4", 4, 1, 0);
    step_chk("wt5", 5, 1, 0);
    step_chk("wt6", 6, 1, 0);
    step_chk("wt7", 0, 0, 1);
    hs_chk("wt7", 0);
    step_chk("n3a", 1, 1, 0);
    step_chk("n3b", 2, 1, 0);
    step_chk("n3c", 0, 0, 1);

    // back to N=5, freeze at cnt=3
    offer(5);
    step_chk("r5a", 1, 1, 0);
    drop();
    step_chk("r5b", 2, 1, 0);
    step_chk("r5c", 0, 0, 1);
    step_chk("f5a", 1, 0, 0);
    step_chk("f5b", 2, 1, 0);
    step_chk("f5c", 3, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) step_chk("frz", 3, 1, 0);
    en = 1'b1;
    step_chk("res4", 4, 1, 0);
    step_chk("res0", 0, 0, 1);

    // queue ratio 8 and run to cnt=3 with it pending
    offer(8);
    step_chk("l8a", 1, 0, 0);
    drop();
    step_chk("l8b", 2, 1, 0);
    step_chk("l8c", 3, 1, 0);
    hs_chk("l8c", 1);

`ifdef CLKDIV_PHASE_RESTART_EN
    restart = 1'b1;
    step_chk("rsa", 0, 0, 1);
    hs_chk("rsa", 0);
    restart = 1'b0;
    step_chk("n8a", 1, 0, 0);
    step_chk("n8b", 2, 0, 0);
    step_chk("n8c", 3, 0, 0);
    step_chk("n8d", 4, 1, 0);
    step_chk("n8e", 5, 1, 0);
    step_chk("n8f", 6, 1, 0);
    step_chk("n8g", 7, 1, 0);
    step_chk("n8h", 0, 0, 1);
    offer(8);
    step_chk("m8a", 1, 0, 0);
    drop();
    step_chk("m8b", 2, 0, 0);
    step_chk("m8c", 3, 0, 0);
    hs_chk("m8c", 1);
`endif

    // reset mid-period discards the pending ratio
    rst = 1'b1;
    step_chk("mr", 0, 0, 0);
    hs_chk("mr", 0);
    rst = 1'b0;
    step_chk("pr1", 1, 1, 0);
    step_chk("pr2", 0, 0, 1);
    step_chk("pr3", 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
